nonrestoring_divider: RTL and testbench
=======================================

// Module: nonrestoring_divider
// PURPOSE
//  Sequential radix-2 non-restoring divider. It is the inverse companion of the booth multiplier, built for the same 32-bit arithmetic benchmark on the Nexys 4 DDR.
//  It accepts a dividend and a divisor on a start pulse and iterates one quotient bit per clock.
//  It returns the quotient and remainder with a one-cycle done pulse, and sits beside the multipliers in the comparison top level.
// PARAMETERS
//  N  8  operand width in bits (dividend, divisor, quotient, remainder); legal N >= 2
// PORTS
//  clk_100MHz   in   1  single system clock; all state changes on the rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  start        in   1  request; sampled only in IDLE
//  data_inD     in   N  dividend
//  data_inV     in   N  divisor
//  quot         out  N  quotient, registered
//  rem          out  N  remainder, registered
//  busy         out  1  high in RUN and FIX
//  done         out  1  one-cycle pulse; quot/rem/div_by_zero valid from this cycle
//  div_by_zero  out  1  divisor was 0 for the last completed operation
// BEHAVIOUR
//  - Reset (asynchronous, active-low): state=IDLE; quot, rem, busy, done and div_by_zero all 0.
//    Reset mid-operation aborts the operation and produces no done.
//  - FSM states: IDLE -> RUN -> FIX -> IDLE.
//  - IDLE with start=1 and data_inV!=0, at edge e0:
//    - latch operands;
//    - A (N+1 bits) = 0; Q = dividend (or its magnitude); cnt = N;
//    - div_by_zero <= 0; state -> RUN.
//  - IDLE with start=1 and data_inV==0, at edge e0:
//    - quot <= all ones; rem <= data_inD; div_by_zero <= 1; done <= 1; stay in IDLE.
//    - No iterations are performed.
//  - RUN, one iteration per edge, N edges total (e1..eN):
//    - shift {A,Q} left by 1;
//    - if A >= 0, A = A - V; else A = A + V;
//    - Q[0] = ~A[N] (the new sign);
//    - cnt decrements; on the edge where cnt reaches 0, state -> FIX.
//  - FIX, at edge eN+1:
//    - if A < 0, A = A + V (remainder restore);
//    - apply sign correction (see CONFIGURATION);
//    - register quot/rem; done <= 1; state -> IDLE.
//  - Latency: done is high in the cycle after eN+1, which is N+1 edges after the edge that sampled start. done is high for exactly 1 cycle.
//  - quot, rem and div_by_zero hold their values until the next completion or reset.
//  - start while busy=1 is ignored; no queueing.
//    - start high in the done cycle is accepted, because the FSM is already in IDLE.
//  - Operand inputs are sampled only at e0; changes during RUN have no effect.
//  - Dividend < divisor (unsigned): quot = 0, rem = dividend.
// CONFIGURATION
//  SIGNED_DIV_EN
//   - defined: operands are two's complement.
//     - Iterate on magnitudes.
//     - quot is negated when sign(D) ^ sign(V) = 1.
//     - rem takes the sign of the dividend (truncating division).
//     - Most-negative / -1: quot = 1 followed by N-1 zeros (wraps), rem = 0, no flag.
//     - Divide by zero behaves as in BEHAVIOUR (quot all ones, rem = data_inD).
//   - undefined: operands are unsigned; no sign logic is synthesised; latency is unchanged.
// TESTING (N=8)
//  1. D=0x27 (39), V=0x1F (31), start 1 cycle -> done exactly 9 edges later; quot=0x01, rem=0x08, div_by_zero=0.
//  2. D=0xC8 (200), V=0x07, unsigned build -> quot=0x1C, rem=0x04; busy high for 9 cycles.
//  3. D=0x1F, V=0x27 -> quot=0x00, rem=0x1F.
//  4. D=0xFF, V=0x00 -> done the cycle after the start edge; quot=0xFF, rem=0xFF, div_by_zero=1, busy never high.
//  5. SIGNED_DIV_EN: D=0xF9 (-7), V=0x02 -> quot=0xFD (-3), rem=0xFF (-1); D=0x80, V=0xFF -> quot=0x80, rem=0x00.
//  6. Back-to-back and abort cases:
//     - start held high continuously -> a new operation begins in each done cycle.
//     - rst_n=0 at iteration 4 -> outputs 0 immediately, no done.
//     - a following start runs normally.

Source files
------------

// File: rtl/nonrestoring_divider.sv
// Sequential radix-2 non-restoring divider: one quotient bit per clock, then a fix-up cycle.
// Optional `SIGNED_DIV_EN selects two's-complement operands (truncating division).
module nonrestoring_divider #(
  parameter int N = 8
) (
  input  logic         clk_100MHz,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] data_inD,
  input  logic [N-1:0] data_inV,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic signed [N:0] acc;
  logic [N-1:0]      q_reg;
  logic [N-1:0]      v_reg;
  logic signed [N:0] v_ext;
  logic signed [N:0] acc_sh;
  logic signed [N:0] acc_step;
  logic [N-1:0]      q_step;
  logic [N-1:0]      rem_raw;
  logic [N-1:0]      quot_fin;
  logic [N-1:0]      rem_fin;
  logic              accept;

`ifdef SIGNED_DIV_EN
  logic sign_q;
  logic sign_r;

  function automatic logic [N-1:0] magnitude(input logic [N-1:0] x);
    return x[N-1] ? (~x + N'(1)) : x;
  endfunction

  function automatic logic [N-1:0] apply_sign(input logic [N-1:0] x, input logic neg);
    return neg ? (~x + N'(1)) : x;
  endfunction
`endif

  assign accept = (state == IDLE) && start && (data_inV != '0);
  assign busy   = (state == RUN) || (state == FIX);

  // Iteration datapath: sign of the old partial remainder picks subtract or add.
  always_comb begin
    v_ext    = {1'b0, v_reg};
    acc_sh   = {acc[N-1:0], q_reg[N-1]};
    acc_step = acc[N] ? (acc_sh + v_ext) : (acc_sh - v_ext);
    q_step   = {q_reg[N-2:0], ~acc_step[N]};
    // Final remainder lies in [0, V), so the restore fits in N bits.
    rem_raw  = acc[N] ? (acc[N-1:0] + v_reg) : acc[N-1:0];
`ifdef SIGNED_DIV_EN
    quot_fin = apply_sign(q_reg, sign_q);
    rem_fin  = apply_sign(rem_raw, sign_r);
`else
    quot_fin = q_reg;
    rem_fin  = rem_raw;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      quot        <= '0;
      rem         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && data_inV == '0) begin
            quot        <= '1;
            rem         <= data_inD;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end else if (accept) begin
            div_by_zero <= 1'b0;
            cnt         <= CW'(N);
          end
        end
        RUN: cnt <= cnt - CW'(1);
        FIX: begin
          quot <= quot_fin;
          rem  <= rem_fin;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand and partial-remainder registers carry no reset; they are loaded on accept.
  always_ff @(posedge clk_100MHz) begin
    if (accept) begin
      acc <= '0;
`ifdef SIGNED_DIV_EN
      q_reg  <= magnitude(data_inD);
      v_reg  <= magnitude(data_inV);
      sign_q <= data_inD[N-1] ^ data_inV[N-1];
      sign_r <= data_inD[N-1];
`else
      q_reg <= data_inD;
      v_reg <= data_inV;
`endif
    end else if (state == RUN) begin
      acc   <= acc_step;
      q_reg <= q_step;
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider (N=8) against an arithmetic reference model.
module tb_nonrestoring_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dd;
  logic [N-1:0] dv;
  logic [N-1:0] quot;
  logic [N-1:0] rem;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  nonrestoring_divider #(.N(N)) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_inD   (dd),
    .data_inV   (dv),
    .quot       (quot),
    .rem        (rem),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer division, divide-by-zero gives all ones / dividend.
  task automatic model(input logic [N-1:0] d, input logic [N-1:0] v,
                       output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
    int qi, ri;
    z = (v == 0);
    if (v == 0) begin
      q = '1;
      r = d;
    end else begin
`ifdef SIGNED_DIV_EN
      qi = int'($signed(d)) / int'($signed(v));
      ri = int'($signed(d)) % int'($signed(v));
`else
      qi = int'(d) / int'(v);
      ri = int'(d) % int'(v);
`endif
      q = qi[N-1:0];
      r = ri[N-1:0];
    end
  endtask

  // Issue one start pulse; report edges from the sampling edge to done, and busy cycles.
  task automatic do_op(input logic [N-1:0] d, input logic [N-1:0] v,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1;
    dd    = d;
    dv    = v;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    for (int k = 0; k <= N + 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 2) begin
        dd = N'($urandom);
        dv = N'($urandom);
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    dd    = '0;
    dv    = '0;
    #3 rst_n = 1'b0;
    #4;
    checks++;
    if ({quot, rem, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_async: got quot=%h rem=%h busy=%b done=%b dbz=%b, want all 0",
               quot, rem, busy, done, div_by_zero);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({quot, rem, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_held: got quot=%h rem=%h busy=%b done=%b dbz=%b, want all 0",
               quot, rem, busy, done, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [N-1:0] d_t[4];
    logic [N-1:0] v_t[4];
    logic [N-1:0] eq, er;
    logic ez;
    int lat, bc, elat, ebc;
    d_t = '{8'h27, 8'hC8, 8'h1F, 8'hFF};
    v_t = '{8'h1F, 8'h07, 8'h27, 8'h00};
    for (int i = 0; i < 4; i++) begin
      do_op(d_t[i], v_t[i], lat, bc);
      model(d_t[i], v_t[i], eq, er, ez);
      elat = ez ? 0 : N + 1;
      ebc  = ez ? 0 : N + 1;
      checks++;
      if (lat !== elat) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d, want %0d", i, lat, elat);
      end
      checks++;
      if (bc !== ebc) begin
        errors++;
        $display("FAIL vec%0d_busy_cycles: got %0d, want %0d", i, bc, ebc);
      end
      checks++;
      if ({quot, rem, div_by_zero} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL vec%0d_result: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                 i, quot, rem, div_by_zero, eq, er, ez);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_done_width: done=%b in following cycle, want 0", i, done);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({quot, rem, div_by_zero} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL vec%0d_hold: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                 i, quot, rem, div_by_zero, eq, er, ez);
      end
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    logic [N-1:0] d_t[3];
    logic [N-1:0] v_t[3];
    logic [N-1:0] eq, er;
    logic ez;
    int lat, bc;
    d_t = '{8'hF9, 8'h80, 8'h07};
    v_t = '{8'h02, 8'hFF, 8'hFE};
    for (int i = 0; i < 3; i++) begin
      do_op(d_t[i], v_t[i], lat, bc);
      model(d_t[i], v_t[i], eq, er, ez);
      checks++;
      if ({quot, rem, div_by_zero} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL signed%0d: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                 i, quot, rem, div_by_zero, eq, er, ez);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] d, v, eq, er;
    logic ez;
    int lat, elat, bc;
    for (int i = 0; i < 40; i++) begin
      d = N'($urandom);
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = N'($urandom_range(1, 4));
        default: v = N'($urandom);
      endcase
      do_op(d, v, lat, bc);
      model(d, v, eq, er, ez);
      elat = ez ? 0 : N + 1;
      checks++;
      if (lat !== elat || {quot, rem, div_by_zero} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL random%0d d=%h v=%h: got q=%h r=%h z=%b lat=%0d, want q=%h r=%h z=%b lat=%0d",
                 i, d, v, quot, rem, div_by_zero, lat, eq, er, ez, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] qd[$];
    logic [N-1:0] qv[$];
    logic [N-1:0] d, v, eq, er;
    logic ez;
    int last_t, results;
    last_t  = -1;
    results = 0;
    @(negedge clk);
    d = N'($urandom);
    v = N'($urandom_range(1, 255));
    start = 1'b1;
    dd = d;
    dv = v;
    qd.push_back(d);
    qv.push_back(v);
    for (int t = 0; t < 60 && results < 4; t++) begin
      @(posedge clk);
      #1;
      if (done) begin
        model(qd.pop_front(), qv.pop_front(), eq, er, ez);
        checks++;
        if ({quot, rem, div_by_zero} !== {eq, er, ez}) begin
          errors++;
          $display("FAIL b2b%0d_result: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                   results, quot, rem, div_by_zero, eq, er, ez);
        end
        checks++;
        if (t - last_t !== ((last_t < 0) ? N + 2 : N + 2)) begin
          errors++;
          $display("FAIL b2b%0d_spacing: got %0d edges, want %0d", results, t - last_t, N + 2);
        end
        last_t = t;
        results++;
        if (results < 4) begin
          d = N'($urandom);
          v = N'($urandom_range(1, 255));
          dd = d;
          dv = v;
          qd.push_back(d);
          qv.push_back(v);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (results !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d completions, want 4", results);
    end
  endtask

  task automatic test_abort();
    logic [N-1:0] eq, er;
    logic ez;
    int seen, lat, bc;
    @(negedge clk);
    start = 1'b1;
    dd = 8'h64;
    dv = 8'h03;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({quot, rem, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got quot=%h rem=%h busy=%b done=%b dbz=%b, want all 0",
               quot, rem, busy, done, div_by_zero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles after abort, want 0", seen);
    end
    do_op(8'hB5, 8'h0A, lat, bc);
    model(8'hB5, 8'h0A, eq, er, ez);
    checks++;
    if (lat !== N + 1 || {quot, rem, div_by_zero} !== {eq, er, ez}) begin
      errors++;
      $display("FAIL after_abort: got q=%h r=%h z=%b lat=%0d, want q=%h r=%h z=%b lat=%0d",
               quot, rem, div_by_zero, lat, eq, er, ez, N + 1);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    test_random();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
